// File: rtl/cmd_gather.sv
// UART command front end: 8N1 receiver, 16-entry first-word-fall-through byte FIFO,
// and a parser that frames 'R'/'W' byte sequences into 72-bit command packets.
package cmd_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_packet_t;
endpackage

module cmd_gather
  import cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_in,
  input  logic        baud_tick,
  input  logic        baud_half_tick,
  output logic        cmd_fifo_wr_en,
  output cmd_packet_t cmd_fifo_wr_data
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [7:0]          LP_OP_RD = 8'h52;
  localparam logic [7:0]          LP_OP_WR = 8'h57;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA, P_EMIT} p_state_t;

  // Bit timing comes solely from the half-bit strobe; the boundary tick is unused.
  logic w_unused_baud_tick;
  assign w_unused_baud_tick = baud_tick;

  logic                  r_rx_meta, r_rx_s, r_rx_prev;
  rx_state_t             r_rx_state;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shreg;
  logic                  r_rx_wr_en;

  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_fifo_valid, w_full, w_push, w_pop, w_byte_rd_en;
  logic [7:0]            w_fifo_rd_data;

  p_state_t              r_p_state;
  logic [1:0]            r_idx;
  logic [7:0]            r_opcode;
  logic [31:0]           r_addr, r_data;
  logic                  r_cmd_wr_en;
  cmd_packet_t           r_cmd_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_in;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shreg    <= 8'h00;
      r_rx_wr_en <= 1'b0;
    end else begin
      r_rx_wr_en <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (baud_half_tick) begin
            if (!r_rx_s) begin
              r_rx_state <= RX_DATA;
              r_bit_cnt  <= 3'd0;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (baud_half_tick) begin
            r_shreg   <= {r_rx_s, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // A low stop bit is a framing error: the byte is silently dropped.
          if (baud_half_tick) begin
            r_rx_wr_en <= r_rx_s;
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_fifo_valid   = (r_count != '0);
  assign w_full         = (r_count == LP_DEPTH);
  assign w_fifo_rd_data = r_mem[r_rd_ptr];
  assign w_byte_rd_en   = w_fifo_valid && (r_p_state != P_EMIT);
  assign w_pop          = w_byte_rd_en;
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign w_push         = r_rx_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_state     <= P_IDLE;
      r_idx         <= 2'd0;
      r_opcode      <= 8'h00;
      r_addr        <= 32'h0;
      r_data        <= 32'h0;
      r_cmd_wr_en   <= 1'b0;
      r_cmd_wr_data <= '0;
    end else begin
      r_cmd_wr_en <= 1'b0;
      case (r_p_state)
        P_IDLE: begin
          if (w_byte_rd_en && (w_fifo_rd_data == LP_OP_RD || w_fifo_rd_data == LP_OP_WR)) begin
            r_opcode  <= w_fifo_rd_data;
            r_idx     <= 2'd0;
            r_p_state <= P_ADDR;
          end
        end
        P_ADDR: begin
          if (w_byte_rd_en) begin
            r_addr <= {r_addr[23:0], w_fifo_rd_data};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (r_opcode == LP_OP_WR) begin
                r_idx     <= 2'd0;
                r_p_state <= P_DATA;
              end else begin
                r_data    <= 32'h0;
                r_p_state <= P_EMIT;
              end
            end
          end
        end
        P_DATA: begin
          if (w_byte_rd_en) begin
            r_data <= {r_data[23:0], w_fifo_rd_data};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_p_state <= P_EMIT;
          end
        end
        P_EMIT: begin
          r_cmd_wr_data <= '{opcode: r_opcode, addr: r_addr, data: r_data};
          r_cmd_wr_en   <= 1'b1;
          r_opcode      <= 8'h00;
          r_addr        <= 32'h0;
          r_data        <= 32'h0;
          r_p_state     <= P_IDLE;
        end
        default: r_p_state <= P_IDLE;
      endcase
    end
  end

  assign cmd_fifo_wr_en   = r_cmd_wr_en;
  assign cmd_fifo_wr_data = r_cmd_wr_data;

endmodule

// File: tb/tb_cmd_gather.sv
// Bench for cmd_gather: UART byte driver, queue-based framing model, pulse monitor,
// directed scenarios followed by randomized frames.
module tb_cmd_gather;
  import cmd_pkg::*;

  logic        clk;
  logic        rst;
  logic        uart_rx_in;
  logic        baud_tick;
  logic        baud_half_tick;
  logic        cmd_fifo_wr_en;
  cmd_packet_t cmd_fifo_wr_data;

  int          errors;
  int          checks;
  int          acceptedBytes;
  logic [2:0]  baudCnt;
  logic [71:0] gotQ[$];
  logic [71:0] expQ[$];
  logic [7:0]  pend[$];
  logic [71:0] lastExp;

  cmd_gather dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rx_in      (uart_rx_in),
    .baud_tick       (baud_tick),
    .baud_half_tick  (baud_half_tick),
    .cmd_fifo_wr_en  (cmd_fifo_wr_en),
    .cmd_fifo_wr_data(cmd_fifo_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Eight clocks per bit; the half tick lands four clocks into each bit.
  initial begin
    baudCnt        = 3'd0;
    baud_tick      = 1'b1;
    baud_half_tick = 1'b0;
    forever begin
      @(negedge clk);
      baudCnt        = baudCnt + 3'd1;
      baud_tick      = (baudCnt == 3'd0);
      baud_half_tick = (baudCnt == 3'd4);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmd_fifo_wr_en === 1'b1) gotQ.push_back(cmd_fifo_wr_data);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Framing rules: non-opcode bytes at the head are discarded; an 'R' needs 5 bytes,
  // a 'W' needs 9, addr and data are big-endian, and reads carry zero data.
  task automatic modelByte(input logic [7:0] b);
    logic [71:0] cmd;
    pend.push_back(b);
    forever begin
      if (pend.size() == 0) break;
      if (pend[0] != 8'h52 && pend[0] != 8'h57) begin
        void'(pend.pop_front());
      end else if (pend[0] == 8'h52 && pend.size() >= 5) begin
        cmd = {pend[0], pend[1], pend[2], pend[3], pend[4], 32'h0};
        expQ.push_back(cmd);
        lastExp = cmd;
        repeat (5) void'(pend.pop_front());
      end else if (pend[0] == 8'h57 && pend.size() >= 9) begin
        cmd = {pend[0], pend[1], pend[2], pend[3], pend[4], pend[5], pend[6], pend[7], pend[8]};
        expQ.push_back(cmd);
        lastExp = cmd;
        repeat (9) void'(pend.pop_front());
      end else begin
        break;
      end
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(posedge clk);
    while (baudCnt != 3'd0) @(posedge clk);
    #1 uart_rx_in = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx_in = b[i];
      repeat (8) @(posedge clk);
    end
    #1 uart_rx_in = stopBit;
    repeat (8) @(posedge clk);
    #1 uart_rx_in = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit stored);
    sendByte(b, stopBit);
    if (stopBit && stored) begin
      modelByte(b);
      acceptedBytes++;
    end
  endtask

  task automatic sendFrame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(op, 1'b1, 1'b1);
    for (int i = 3; i >= 0; i--) applyStimulus(addr[8*i +: 8], 1'b1, 1'b1);
    if (op == 8'h57)
      for (int i = 3; i >= 0; i--) applyStimulus(data[8*i +: 8], 1'b1, 1'b1);
  endtask

  task automatic compareCommands(input string tag);
    logic [71:0] obs;
    repeat (30) @(posedge clk);
    #1;
    checkOutput({tag, "_count"}, 72'(gotQ.size()), 72'(expQ.size()));
    foreach (expQ[i]) begin
      obs = (i < gotQ.size()) ? gotQ[i] : 'x;
      checkOutput($sformatf("%s_cmd%0d", tag, i), obs, expQ[i]);
    end
    checkOutput({tag, "_hold"}, cmd_fifo_wr_data, lastExp);
    checkOutput({tag, "_wren_idle"}, 72'(cmd_fifo_wr_en), 72'(0));
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic clearModel();
    pend.delete();
    expQ.delete();
    gotQ.delete();
    lastExp       = 72'h0;
    acceptedBytes = 0;
  endtask

  initial begin
    logic [7:0]  fillBytes [17];
    logic [7:0]  garbage;
    logic [31:0] rAddr, rData;
    int          kind;
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    uart_rx_in = 1'b1;
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wren", 72'(cmd_fifo_wr_en), 72'(0));
    checkOutput("reset_data", cmd_fifo_wr_data, 72'h0);
    checkOutput("reset_count", 72'(dut.r_count), 72'(0));
    rst = 1'b0;
    repeat (5) @(posedge clk);

    sendFrame(8'h52, 32'h0000_1000, 32'h0);
    checkOutput("read_model", expQ[0], 72'h52_00001000_00000000);
    compareCommands("read");

    for (int i = 0; i < 8; i++) applyStimulus(8'(72'h57_DEADBEEF_12345678 >> (64 - 8*i)), 1'b1, 1'b1);
    repeat (30) @(posedge clk);
    #1 checkOutput("write_early", 72'(gotQ.size()), 72'(0));
    applyStimulus(8'h78, 1'b1, 1'b1);
    compareCommands("write");

    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    sendFrame(8'h52, 32'h0000_0004, 32'h0);
    compareCommands("garbage");

    applyStimulus(8'hA7, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1 checkOutput("frame_err_wrptr", 72'(dut.r_wr_ptr), 72'(acceptedBytes % 16));
    sendFrame(8'h52, 32'h0, 32'h0);
    compareCommands("frame_err");

    // Leave a half-received 'W' in the parser, then reset mid UART byte.
    applyStimulus(8'h57, 1'b1, 1'b1);
    applyStimulus(8'h11, 1'b1, 1'b1);
    fork
      sendByte(8'hA5, 1'b1);
      begin
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_wren", 72'(cmd_fifo_wr_en), 72'(0));
        checkOutput("async_data", cmd_fifo_wr_data, 72'h0);
        checkOutput("async_count", 72'(dut.r_count), 72'(0));
        checkOutput("async_ptrs", 72'({dut.r_wr_ptr, dut.r_rd_ptr}), 72'(0));
      end
    join
    clearModel();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sendFrame(8'h52, 32'hCAFE_0001, 32'h0);
    compareCommands("post_reset");

    fillBytes = '{8'h52, 8'h01, 8'h02, 8'h03, 8'h04, 8'h57, 8'h11, 8'h22, 8'h33,
                  8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h52, 8'hAA, 8'hEE};
    force dut.w_byte_rd_en = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus(fillBytes[i], 1'b1, i < 16);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("full_count", 72'(dut.r_count), 72'(16));
    checkOutput("full_wrptr", 72'(dut.r_wr_ptr), 72'(acceptedBytes % 16));
    checkOutput("full_no_cmd", 72'(gotQ.size()), 72'(0));
    release dut.w_byte_rd_en;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("drain_count", 72'(dut.r_count), 72'(0));
    checkOutput("drain_rdptr", 72'(dut.r_rd_ptr), 72'(acceptedBytes % 16));
    compareCommands("drain");
    applyStimulus(8'hBB, 1'b1, 1'b1);
    applyStimulus(8'hCC, 1'b1, 1'b1);
    applyStimulus(8'hDD, 1'b1, 1'b1);
    compareCommands("after_full");

    for (int n = 0; n < 8; n++) begin
      kind  = $urandom_range(0, 3);
      rAddr = $urandom;
      rData = $urandom;
      case (kind)
        0: begin
          do garbage = 8'($urandom_range(0, 255));
          while (garbage == 8'h52 || garbage == 8'h57);
          applyStimulus(garbage, 1'b1, 1'b1);
          sendFrame(8'h57, rAddr, rData);
        end
        1: sendFrame(8'h52, rAddr, rData);
        2: sendFrame(8'h57, rAddr, rData);
        default: begin
          applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b1);
          sendFrame(8'h52, rAddr, rData);
        end
      endcase
      compareCommands($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
